// File: rtl/mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_arbiter: round-robin I/D cache line arbiter, 4-word bursts with timeout
// Revision: 1.0
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic        i_rvalid,
  output logic [15:0] i_rdata,
  output logic [1:0]  i_widx,
  output logic        i_done,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_rvalid,
  output logic [15:0] d_rdata,
  output logic [1:0]  d_widx,
  output logic        d_done,
  output logic        d_err,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int   CW    = $clog2(TIMEOUT + 1);
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            owner_q, owner_d;
  logic            wr_q, wr_d;
  logic            last_q, last_d;
  logic [15:0]     base_q, base_d;
  logic [1:0]      k_q, k_d;
  logic [CW-1:0]   tcnt_q, tcnt_d;

  logic            w_take_d;
  logic            w_timeout;
  logic            w_unused;

  // D wins unless I is also asking and D was the most recent owner
  assign w_take_d  = d_req & (~i_req | (last_q == OWN_I));
  assign w_timeout = (state_q == S_BUSY) && (tcnt_q == CW'(TIMEOUT));
  assign w_unused  = ^{i_addr[2:0], d_addr[2:0]};

  assign mem_wdata = (!rst && state_q == S_BUSY && !w_timeout) ? d_wdata : 16'h0000;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      owner_q <= OWN_I;
      wr_q    <= 1'b0;
      last_q  <= OWN_I;
      base_q  <= 16'h0000;
      k_q     <= 2'd0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      wr_q    <= wr_d;
      last_q  <= last_d;
      base_q  <= base_d;
      k_q     <= k_d;
      tcnt_q  <= tcnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    wr_d     = wr_q;
    last_d   = last_q;
    base_d   = base_q;
    k_d      = k_q;
    tcnt_d   = tcnt_q;
    i_rvalid = 1'b0;
    i_rdata  = 16'h0000;
    i_widx   = 2'd0;
    i_done   = 1'b0;
    i_err    = 1'b0;
    d_rvalid = 1'b0;
    d_rdata  = 16'h0000;
    d_widx   = 2'd0;
    d_done   = 1'b0;
    d_err    = 1'b0;
    mem_req  = 1'b0;
    mem_wr   = 1'b0;
    mem_addr = 16'h0000;

    case (state_q)
      S_IDLE: begin
        if (i_req || d_req) begin
          owner_d = w_take_d;
          last_d  = w_take_d;
          base_d  = w_take_d ? {d_addr[15:3], 3'b000} : {i_addr[15:3], 3'b000};
          wr_d    = w_take_d & d_wr;
          k_d     = 2'd0;
          tcnt_d  = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (w_timeout) begin
          if (owner_q == OWN_D) d_err = 1'b1;
          else                  i_err = 1'b1;
          k_d     = 2'd0;
          tcnt_d  = '0;
          state_d = S_IDLE;
        end else begin
          mem_req  = 1'b1;
          mem_wr   = wr_q;
          mem_addr = base_q + {13'd0, k_q, 1'b0};
          if (owner_q == OWN_D) d_widx = k_q;
          else                  i_widx = k_q;
          if (mem_ack) begin
            tcnt_d = '0;
            if (!wr_q) begin
              if (owner_q == OWN_D) begin
                d_rvalid = 1'b1;
                d_rdata  = mem_rdata;
              end else begin
                i_rvalid = 1'b1;
                i_rdata  = mem_rdata;
              end
            end
            if (k_q == 2'd3) begin
              k_d     = 2'd0;
              state_d = S_DONE;
            end else begin
              k_d = k_q + 2'd1;
            end
          end else begin
            tcnt_d = tcnt_q + CW'(1);
          end
        end
      end
      S_DONE: begin
        if (owner_q == OWN_D) d_done = 1'b1;
        else                  i_done = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are forced quiet while reset is held, whatever state was left behind
    if (rst) begin
      i_rvalid = 1'b0;
      i_rdata  = 16'h0000;
      i_widx   = 2'd0;
      i_done   = 1'b0;
      i_err    = 1'b0;
      d_rvalid = 1'b0;
      d_rdata  = 16'h0000;
      d_widx   = 2'd0;
      d_done   = 1'b0;
      d_err    = 1'b0;
      mem_req  = 1'b0;
      mem_wr   = 1'b0;
      mem_addr = 16'h0000;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_arbiter: table-driven and sequence checks for mem_arbiter
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst, i_req, d_req, d_wr, mem_ack;
  logic [15:0] i_addr, d_addr, mem_rdata;
  wire  [15:0] d_wdata;
  logic        i_rvalid, i_done, i_err, d_rvalid, d_done, d_err, mem_req, mem_wr;
  logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic [1:0]  i_widx, d_widx;

  int checks   = 0;
  int failures = 0;
  int ncyc     = 0;
  logic [15:0] ia = 16'h0000, da = 16'h0000;
  logic        dwg = 1'b0;

  always #5 clk = ~clk;

  // Data-cache model: writeback data is selected by the word index
  assign d_wdata = 16'hA000 + {14'd0, d_widx};

  mem_arbiter #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .i_widx(i_widx), .i_done(i_done), .i_err(i_err),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_widx(d_widx), .d_done(d_done), .d_err(d_err),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  typedef struct packed {
    logic rst, ireq; logic [15:0] iaddr;
    logic dreq, dwr; logic [15:0] daddr;
    logic ack; logic [15:0] rd;
  } in_t;

  typedef struct packed {
    logic mreq, mwr; logic [15:0] maddr, mwdata;
    logic irv; logic [15:0] ird; logic [1:0] iw; logic idone, ierr;
    logic drv; logic [15:0] drd; logic [1:0] dw; logic ddone, derr;
  } exp_t;

  typedef struct packed { in_t in; exp_t ex; } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic ir, logic [15:0] iad, logic dr, logic dwr,
                              logic [15:0] dad, logic ack, logic [15:0] rd,
                              logic mreq, logic mwr, logic [15:0] maddr, logic [15:0] mwd,
                              logic irv, logic [15:0] ird, logic [1:0] iw, logic idone,
                              logic drv, logic [1:0] dw, logic ddone);
    vec_t v;
    v.in = '{r, ir, iad, dr, dwr, dad, ack, rd};
    v.ex = '{mreq, mwr, maddr, mwd, irv, ird, iw, idone, 1'b0, drv, 16'h0000, dw, ddone, 1'b0};
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input exp_t e);
    chk({tag, ".mem_req"},   mem_req,   e.mreq);
    chk({tag, ".mem_wr"},    mem_wr,    e.mwr);
    chk({tag, ".mem_addr"},  mem_addr,  e.maddr);
    chk({tag, ".mem_wdata"}, mem_wdata, e.mwdata);
    chk({tag, ".i_rvalid"},  i_rvalid,  e.irv);
    chk({tag, ".i_rdata"},   i_rdata,   e.ird);
    chk({tag, ".i_widx"},    i_widx,    e.iw);
    chk({tag, ".i_done"},    i_done,    e.idone);
    chk({tag, ".i_err"},     i_err,     e.ierr);
    chk({tag, ".d_rvalid"},  d_rvalid,  e.drv);
    chk({tag, ".d_rdata"},   d_rdata,   e.drd);
    chk({tag, ".d_widx"},    d_widx,    e.dw);
    chk({tag, ".d_done"},    d_done,    e.ddone);
    chk({tag, ".d_err"},     d_err,     e.derr);
  endtask

  task automatic cyc(input logic r, input logic ir, input logic dr, input logic ack);
    @(negedge clk);
    rst = r; i_req = ir; d_req = dr; mem_ack = ack;
    i_addr = ia; d_addr = da; d_wr = dwg;
    mem_rdata = 16'hC000 + 16'(ncyc);
    ncyc++;
    #1;
  endtask

  // Four back-to-back acked words for the given owner
  task automatic words(input string tag, input logic own_d, input logic [15:0] base,
                       input logic ir, input logic dr);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, ir, dr, 1'b1);
      chk($sformatf("%s.w%0d.mem_req", tag, k),  mem_req, 16'd1);
      chk($sformatf("%s.w%0d.mem_addr", tag, k), mem_addr, base + 16'(2 * k));
      chk($sformatf("%s.w%0d.mem_wr", tag, k),   mem_wr, own_d & dwg);
      chk($sformatf("%s.w%0d.i_rvalid", tag, k), i_rvalid, !own_d);
      chk($sformatf("%s.w%0d.d_rvalid", tag, k), d_rvalid, own_d & !dwg);
      chk($sformatf("%s.w%0d.rdata", tag, k),    own_d ? d_rdata : i_rdata,
          (own_d && dwg) ? 16'h0000 : mem_rdata);
      chk($sformatf("%s.w%0d.widx", tag, k),     own_d ? d_widx : i_widx, 16'(k));
      chk($sformatf("%s.w%0d.other_idle", tag, k),
          own_d ? {i_widx, i_done, i_err} : {d_widx, d_done, d_err}, 16'd0);
    end
  endtask

  task automatic done_chk(input string tag, input logic own_d);
    chk({tag, ".i_done"},  i_done,  !own_d);
    chk({tag, ".d_done"},  d_done,  own_d);
    chk({tag, ".mem_req"}, mem_req, 16'd0);
    chk({tag, ".errs"},    {i_err, d_err}, 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0; mem_ack = 1'b0;
    i_addr = 16'h0000; d_addr = 16'h0000; mem_rdata = 16'h0000;

    // I-only fill with 2-cycle ack latency and an address change mid-burst,
    // then a D writeback with zero-latency acks and stray acks in DONE/IDLE.
    tbl.push_back(mk(1,0,16'h0000,0,0,16'h0000,0,16'h0000, 0,0,16'h0000,16'h0000,0,16'h0000,0,0,0,0,0));
    tbl.push_back(mk(0,1,16'h1236,0,0,16'h0000,0,16'h0000, 0,0,16'h0000,16'h0000,0,16'h0000,0,0,0,0,0));
    tbl.push_back(mk(0,1,16'h1236,0,0,16'h0000,0,16'h0000, 1,0,16'h1230,16'hA000,0,16'h0000,0,0,0,0,0));
    tbl.push_back(mk(0,1,16'h1236,0,0,16'h0000,0,16'h0000, 1,0,16'h1230,16'hA000,0,16'h0000,0,0,0,0,0));
    tbl.push_back(mk(0,1,16'h1236,0,0,16'h0000,1,16'h1111, 1,0,16'h1230,16'hA000,1,16'h1111,0,0,0,0,0));
    tbl.push_back(mk(0,1,16'hFFF8,0,0,16'h0000,0,16'h0000, 1,0,16'h1232,16'hA000,0,16'h0000,1,0,0,0,0));
    tbl.push_back(mk(0,1,16'hFFF8,0,0,16'h0000,0,16'h0000, 1,0,16'h1232,16'hA000,0,16'h0000,1,0,0,0,0));
    tbl.push_back(mk(0,1,16'hFFF8,0,0,16'h0000,1,16'h2222, 1,0,16'h1232,16'hA000,1,16'h2222,1,0,0,0,0));
    tbl.push_back(mk(0,1,16'hFFF8,0,0,16'h0000,0,16'h0000, 1,0,16'h1234,16'hA000,0,16'h0000,2,0,0,0,0));
    tbl.push_back(mk(0,1,16'hFFF8,0,0,16'h0000,0,16'h0000, 1,0,16'h1234,16'hA000,0,16'h0000,2,0,0,0,0));
    tbl.push_back(mk(0,1,16'hFFF8,0,0,16'h0000,1,16'h3333, 1,0,16'h1234,16'hA000,1,16'h3333,2,0,0,0,0));
    tbl.push_back(mk(0,1,16'hFFF8,0,0,16'h0000,0,16'h0000, 1,0,16'h1236,16'hA000,0,16'h0000,3,0,0,0,0));
    tbl.push_back(mk(0,1,16'hFFF8,0,0,16'h0000,0,16'h0000, 1,0,16'h1236,16'hA000,0,16'h0000,3,0,0,0,0));
    tbl.push_back(mk(0,1,16'hFFF8,0,0,16'h0000,1,16'h4444, 1,0,16'h1236,16'hA000,1,16'h4444,3,0,0,0,0));
    tbl.push_back(mk(0,0,16'h0000,0,0,16'h0000,0,16'h0000, 0,0,16'h0000,16'h0000,0,16'h0000,0,1,0,0,0));
    tbl.push_back(mk(0,0,16'h0000,0,0,16'h0000,0,16'h0000, 0,0,16'h0000,16'h0000,0,16'h0000,0,0,0,0,0));
    tbl.push_back(mk(0,0,16'h0000,1,1,16'h0040,0,16'h0000, 0,0,16'h0000,16'h0000,0,16'h0000,0,0,0,0,0));
    tbl.push_back(mk(0,0,16'h0000,1,1,16'h0040,1,16'hBEEF, 1,1,16'h0040,16'hA000,0,16'h0000,0,0,0,0,0));
    tbl.push_back(mk(0,0,16'h0000,1,1,16'h0040,1,16'hBEEF, 1,1,16'h0042,16'hA001,0,16'h0000,0,0,0,1,0));
    tbl.push_back(mk(0,0,16'h0000,1,1,16'h0040,1,16'hBEEF, 1,1,16'h0044,16'hA002,0,16'h0000,0,0,0,2,0));
    tbl.push_back(mk(0,0,16'h0000,1,1,16'h0040,1,16'hBEEF, 1,1,16'h0046,16'hA003,0,16'h0000,0,0,0,3,0));
    tbl.push_back(mk(0,0,16'h0000,0,0,16'h0040,1,16'hBEEF, 0,0,16'h0000,16'h0000,0,16'h0000,0,0,0,0,1));
    tbl.push_back(mk(0,0,16'h0000,0,0,16'h0040,1,16'hBEEF, 0,0,16'h0000,16'h0000,0,16'h0000,0,0,0,0,0));

    for (int n = 0; n < tbl.size(); n++) begin
      @(negedge clk);
      rst = tbl[n].in.rst; i_req = tbl[n].in.ireq; i_addr = tbl[n].in.iaddr;
      d_req = tbl[n].in.dreq; d_wr = tbl[n].in.dwr; d_addr = tbl[n].in.daddr;
      mem_ack = tbl[n].in.ack; mem_rdata = tbl[n].in.rd;
      #1;
      check_outs($sformatf("vec%0d", n), tbl[n].ex);
    end

    // Tie after reset: D first, then I, then D again
    ia = 16'h0200; da = 16'h0100; dwg = 1'b0;
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 1);
    check_outs("tie.reset", '0);
    cyc(0, 1, 1, 0);
    chk("tie.idle.mem_req", mem_req, 16'd0);
    words("tie.d1", 1'b1, 16'h0100, 1'b1, 1'b1);
    cyc(0, 1, 0, 0);
    done_chk("tie.d1.done", 1'b1);
    cyc(0, 1, 0, 0);
    chk("tie.dead.mem_req", mem_req, 16'd0);
    words("tie.i", 1'b0, 16'h0200, 1'b1, 1'b0);
    cyc(0, 1, 1, 0);
    done_chk("tie.i.done", 1'b0);
    cyc(0, 1, 1, 0);
    chk("tie.dead2.mem_req", mem_req, 16'd0);
    words("tie.d2", 1'b1, 16'h0100, 1'b1, 1'b1);
    cyc(0, 0, 0, 0);
    done_chk("tie.d2.done", 1'b1);
    cyc(0, 0, 0, 0);
    check_outs("tie.idle_end", '0);

    // Timeout on word 1, then a normal retry
    ia = 16'h0300;
    cyc(0, 1, 0, 0);
    chk("to.idle.mem_req", mem_req, 16'd0);
    cyc(0, 1, 0, 1);
    chk("to.w0.i_rvalid", i_rvalid, 16'd1);
    for (int n = 0; n < 16; n++) begin
      cyc(0, 1, 0, 0);
      chk($sformatf("to.wait%0d.mem_req", n), mem_req, 16'd1);
      chk($sformatf("to.wait%0d.mem_addr", n), mem_addr, 16'h0302);
      chk($sformatf("to.wait%0d.err", n), {i_err, d_err, i_rvalid}, 16'd0);
    end
    cyc(0, 1, 0, 0);
    chk("to.abort.i_err", i_err, 16'd1);
    chk("to.abort.mem_req", mem_req, 16'd0);
    chk("to.abort.done", {i_done, d_done, d_err}, 16'd0);
    cyc(0, 1, 0, 0);
    check_outs("to.idle_after", '0);
    words("to.retry", 1'b0, 16'h0300, 1'b1, 1'b0);
    cyc(0, 0, 0, 0);
    done_chk("to.retry.done", 1'b0);

    // Reset after word 2 of a D fill, stray ack, then a fresh D grant
    da = 16'h0500;
    cyc(0, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 1, 1);
      chk($sformatf("rst.w%0d.d_rvalid", k), d_rvalid, 16'd1);
      chk($sformatf("rst.w%0d.d_widx", k), d_widx, 16'(k));
    end
    cyc(1, 0, 1, 0);
    check_outs("rst.during", '0);
    cyc(0, 0, 0, 1);
    check_outs("rst.stray_ack", '0);
    da = 16'h0600;
    cyc(0, 0, 1, 0);
    check_outs("rst.regrant_idle", '0);
    words("rst.new", 1'b1, 16'h0600, 1'b0, 1'b1);
    cyc(0, 0, 0, 0);
    done_chk("rst.new.done", 1'b1);
    cyc(0, 0, 0, 0);
    check_outs("rst.final_idle", '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, giving the maximum cycles to wait for mem_ack per word before aborting.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port i_req, input, 1, I-cache line-fill request; held until i_done.
REQ-005 SHALL have port i_addr, input, 16, I-cache line address; bits [2:0] ignored.
REQ-006 SHALL have ports i_rvalid (output, 1), i_rdata (output, 16), i_widx (output, 2): per-word fill data and its word index.
REQ-007 SHALL have ports i_done (output, 1) and i_err (output, 1): one-cycle transfer-complete and abort pulses.
REQ-008 SHALL have ports d_req (input, 1), d_wr (input, 1, 1=writeback, 0=fill), d_addr (input, 16), d_wdata (input, 16, word selected by d_widx).
REQ-009 SHALL have ports d_rvalid (output, 1), d_rdata (output, 16), d_widx (output, 2), d_done (output, 1), d_err (output, 1), with the same meaning as the I-side ports.
REQ-010 SHALL have ports mem_req (output, 1), mem_wr (output, 1), mem_addr (output, 16), mem_wdata (output, 16), mem_rdata (input, 16), mem_ack (input, 1, one-cycle completion pulse).

Function
REQ-011 SHALL implement the states IDLE, BUSY, and DONE.
REQ-012 In IDLE, SHALL sample i_req/d_req each cycle; with exactly one asserted, SHALL grant it and enter BUSY next cycle.
REQ-013 With both asserted in IDLE, SHALL grant the side not granted most recently (round-robin via last_grant register).
REQ-014 SHALL capture grant owner, line base address {addr[15:3],3'b000}, and d_wr at the grant edge; later changes to requester inputs are ignored until DONE.
REQ-015 SHALL transfer 4 words per grant, word k (k=0..3) at mem_addr = base + 2k.
REQ-016 In BUSY, SHALL drive mem_req=1, mem_wr=captured wr (always 0 for I grants), mem_addr for current k, mem_wdata=d_wdata, with d_widx=k.
REQ-017 On mem_ack in BUSY, SHALL assert the owner's rvalid for that cycle only (reads only), with rdata=mem_rdata and widx=k, combinationally from mem_ack.
REQ-018 On mem_ack with k<3, SHALL increment k and remain in BUSY; mem_req stays high across words.
REQ-019 On mem_ack with k=3, SHALL enter DONE; in DONE, SHALL pulse the owner's done for one cycle, drive mem_req=0, and return to IDLE.
REQ-020 The non-owner's rvalid/done/err SHALL remain 0 throughout a transfer.
REQ-021 SHALL count cycles in BUSY since the last ack or grant; on reaching TIMEOUT without mem_ack, SHALL pulse the owner's err, set mem_req=0, and return to IDLE without asserting done.
REQ-022 SHALL ignore mem_ack in IDLE and DONE.
REQ-023 Earliest re-grant SHALL be the cycle after DONE (one dead cycle between transfers); a requester that keeps req high after done is re-granted per REQ-012/013.
REQ-024 Gap from the req edge to the first mem_req SHALL be exactly 1 cycle.

Reset
REQ-025 With rst high at posedge, SHALL enter IDLE, k=0, set the timeout counter to 0, and set last_grant=I so that D wins the first tie.
REQ-026 During and after reset, all outputs SHALL be 0 (mem_addr/mem_wdata/rdata/widx = 0x0000/0).
REQ-027 Reset mid-transfer SHALL abort immediately with no done/err pulse.

Verification
REQ-028 I-only fill: i_addr=0x1236, mem_ack 2 cycles after each mem_req -> mem_addr 0x1230,0x1232,0x1234,0x1236; four i_rvalid pulses with i_widx 0..3; i_done once, aligned with the DONE state.
REQ-029 Tie after reset: i_req and d_req rise together -> D granted first, I granted on the cycle after d_done; a second tie then grants D (alternation).
REQ-030 D writeback: d_wr=1, d_addr=0x0040, d_wdata=0xA000+d_widx -> mem_wr=1 with mem_wdata 0xA000..0xA003 at 0x0040..0x0046; d_rvalid never asserted; d_done pulses.
REQ-031 Timeout: mem_ack withheld for 16 cycles on word 1 -> i_err pulses once, i_done never asserts, arbiter is in IDLE next cycle, and a later request completes normally.
REQ-032 Reset mid-transfer after word 2 -> all outputs 0 next cycle; a stray mem_ack in IDLE is ignored; a new d_req is granted normally.
REQ-033 Requester changes i_addr to 0xFFF8 mid-transfer -> mem_addr continues to use the captured base address.
